// File: rtl/uart_rx_deser_if.sv
// Handshake bundle between the UART receive deserialiser and its controller.
// The controller side drives line, rate and FIFO status; the deserialiser returns bytes and flags.
interface uart_rx_deser_if;
    logic       EN;
    logic       RXEN;
    logic [3:0] BAUD;
    logic       RX;
    logic       FULL;
    logic [7:0] DATA;
    logic       VALID;
    logic       FERR;
    logic       OVERRUN;
    logic       PERR;
    logic       BUSY;

    modport master (
        output EN, RXEN, BAUD, RX, FULL,
        input  DATA, VALID, FERR, OVERRUN, PERR, BUSY
    );

    modport slave (
        input  EN, RXEN, BAUD, RX, FULL,
        output DATA, VALID, FERR, OVERRUN, PERR, BUSY
    );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive front end: RX synchroniser, 16x oversampling, 8N1 deserialiser.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors on PERR.
module uart_rx_deser #(
    parameter int CLK_HZ = 100_000_000,
    parameter int OVS    = 16
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_deser_if.slave bus
);

    localparam int SW = $clog2(OVS);
    localparam int D0 = (CLK_HZ + (OVS / 2) * 9600) / (OVS * 9600);
    localparam int D1 = (CLK_HZ + (OVS / 2) * 19200) / (OVS * 19200);
    localparam int D2 = (CLK_HZ + (OVS / 2) * 38400) / (OVS * 38400);
    localparam int D3 = (CLK_HZ + (OVS / 2) * 57600) / (OVS * 57600);
    localparam int D4 = (CLK_HZ + (OVS / 2) * 115200) / (OVS * 115200);
    localparam int D5 = (CLK_HZ + (OVS / 2) * 230400) / (OVS * 230400);
    localparam int D6 = (CLK_HZ + (OVS / 2) * 460800) / (OVS * 460800);
    localparam int D7 = (CLK_HZ + (OVS / 2) * 921600) / (OVS * 921600);
    localparam int CW = $clog2(D0 + 1);

    localparam logic [SW-1:0] SMP_LO  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SMP_MID = SW'(OVS / 2);
    localparam logic [SW-1:0] SMP_HI  = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] SMP_END = SW'(OVS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } state_t;

    function automatic logic [CW-1:0] div_of(input logic [3:0] code);
        case (code)
            4'd0:    div_of = CW'(D0);
            4'd1:    div_of = CW'(D1);
            4'd2:    div_of = CW'(D2);
            4'd3:    div_of = CW'(D3);
            4'd5:    div_of = CW'(D5);
            4'd6:    div_of = CW'(D6);
            4'd7:    div_of = CW'(D7);
            default: div_of = CW'(D4);
        endcase
    endfunction

    state_t        state;
    state_t        state_n;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] div_q;
    logic [CW-1:0] div_in;
    logic [CW-1:0] cnt;
    logic [SW-1:0] samp;
    logic          v_lo;
    logic          v_mid;
    logic          bit_q;
    logic [7:0]    shift;
    logic [2:0]    idx;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          perr_q;
    logic          valid_n;
    logic          ferr_n;
    logic          ovr_n;
    logic          perr_n;
    logic          run;
    logic          tick;
    logic          at_hi;
    logic          at_end;
    logic          maj;
    logic          par_bad;

    assign run    = bus.EN & bus.RXEN;
    assign div_in = div_of(bus.BAUD);
    assign tick   = (state != ST_IDLE) && (cnt == div_q - CW'(1));
    assign at_hi  = tick && (samp == SMP_HI);
    assign at_end = tick && (samp == SMP_END);
    assign maj    = (v_lo & v_mid) | (v_lo & rx_s) | (v_mid & rx_s);

`ifdef UART_RX_PARITY_EN
    logic par_q;
    assign par_bad = ^{shift, par_q};
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        perr_n  = 1'b0;
        if (!run) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) state_n = ST_START;
                end
                ST_START: begin
                    if (at_hi && maj) state_n = ST_IDLE;
                    else if (at_end) state_n = ST_DATA;
                end
                ST_DATA: begin
`ifdef UART_RX_PARITY_EN
                    if (at_end && idx == 3'd7) state_n = ST_PARITY;
`else
                    if (at_end && idx == 3'd7) state_n = ST_STOP;
`endif
                end
                ST_PARITY: begin
                    if (at_end) state_n = ST_STOP;
                end
                ST_STOP: begin
                    if (at_hi) begin
                        if (!maj) begin
                            ferr_n  = 1'b1;
                            state_n = ST_BRK;
                        end else begin
                            perr_n  = par_bad;
                            ovr_n   = !par_bad && bus.FULL;
                            valid_n = !par_bad && !bus.FULL;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_s) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            div_q   <= '0;
            cnt     <= '0;
            samp    <= '0;
            v_lo    <= 1'b0;
            v_mid   <= 1'b0;
            bit_q   <= 1'b0;
            shift   <= '0;
            idx     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            rx_m    <= bus.RX;
            rx_s    <= rx_m;
            state   <= state_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
            perr_q  <= perr_n;
            // The detect cycle counts as the first divider count of the start bit.
            if (state == ST_IDLE) begin
                div_q <= div_in;
                samp  <= '0;
                cnt   <= (state_n == ST_START && div_in != CW'(1)) ? CW'(1) : '0;
            end else if (tick) begin
                cnt  <= '0;
                samp <= samp + SW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (tick && samp == SMP_LO) v_lo <= rx_s;
            if (tick && samp == SMP_MID) v_mid <= rx_s;
            if (at_hi) bit_q <= maj;
            if (state == ST_START && at_end) idx <= '0;
            if (state == ST_DATA && at_end) begin
                shift <= {bit_q, shift[7:1]};
                idx   <= idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (state == ST_PARITY && at_hi) par_q <= maj;
`endif
            if (valid_n) data_q <= shift;
        end
    end

    assign bus.DATA    = data_q;
    assign bus.VALID   = valid_q;
    assign bus.FERR    = ferr_q;
    assign bus.OVERRUN = ovr_q;
    assign bus.PERR    = perr_q;
    assign bus.BUSY    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at a 10 MHz clock (DIV=5 at BAUD=4, DIV=65 at BAUD=0).
// Pulses are counted by a negedge monitor; each task checks its own scenario.
module tb_uart_rx_deser;

    localparam int BT4 = 80;
    localparam int BT0 = 1040;
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = 850;
    localparam int EXP_PERR = 1;
`else
    localparam int LAT      = 770;
    localparam int EXP_PERR = 0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_rx_deser_if bus ();

    uart_rx_deser #(
        .CLK_HZ(10_000_000),
        .OVS   (16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int n_valid, n_ferr, n_ovr, n_perr;
    int n_multi = 0;
    int perr_total = 0;
    logic [7:0] got[$];
    time t_valid, t_fall;

    always @(negedge CLK) begin
        if (RST) begin
            if (bus.VALID) begin
                if (n_valid == 0) t_valid = $time;
                n_valid++;
                got.push_back(bus.DATA);
            end
            if (bus.FERR) n_ferr++;
            if (bus.OVERRUN) n_ovr++;
            if (bus.PERR) begin
                n_perr++;
                perr_total++;
            end
            if (int'(bus.VALID) + int'(bus.FERR) + int'(bus.OVERRUN) + int'(bus.PERR) > 1)
                n_multi++;
        end
    end

    task automatic clear_mon();
        n_valid = 0;
        n_ferr  = 0;
        n_ovr   = 0;
        n_perr  = 0;
        t_valid = 0;
        got.delete();
    endtask

    task automatic send_bit(input logic v, input int n);
        bus.RX = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bt);
        @(negedge CLK);
        t_fall = $time;
        send_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) send_bit(b[i], bt);
`ifdef UART_RX_PARITY_EN
        send_bit(^b, bt);
`endif
        send_bit(stop, bt);
    endtask

    task automatic send_partial(input logic [7:0] b, input int bt);
        @(negedge CLK);
        send_bit(1'b0, bt);
        for (int i = 0; i < 4; i++) send_bit(b[i], bt);
        send_bit(b[4], bt / 2);
    endtask

    task automatic test_reset();
        bus.EN   = 1'b1;
        bus.RXEN = 1'b1;
        bus.BAUD = 4'd4;
        bus.RX   = 1'b1;
        bus.FULL = 1'b0;
        RST      = 1'b0;
        clear_mon();
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h want 00", bus.DATA);
        end
        checks++;
        if ({bus.VALID, bus.FERR, bus.OVERRUN, bus.PERR} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 0000",
                     {bus.VALID, bus.FERR, bus.OVERRUN, bus.PERR});
        end
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", bus.BUSY);
        end
        RST = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_basic();
        time lat;
        clear_mon();
        send_frame(8'hA5, 1'b1, BT4);
        repeat (20) @(negedge CLK);
        lat = t_valid - 5 - t_fall;
        checks++;
        if (n_valid != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d VALID want 1", n_valid);
        end
        checks++;
        if (bus.DATA !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data: got %h want a5", bus.DATA);
        end
        checks++;
        if (lat < (LAT - 2) * 10 || lat > (LAT + 2) * 10) begin
            errors++;
            $display("FAIL basic_latency: got %0t ns want %0d+-20 ns", lat, LAT * 10);
        end
        checks++;
        if (bus.BUSY !== 1'b0 || n_ferr != 0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b ferr=%0d want 0 0", bus.BUSY, n_ferr);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge CLK);
        bus.RX = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hi: got %b want 1", bus.BUSY);
        end
        repeat (9) @(negedge CLK);
        bus.RX = 1'b1;
        repeat (80) @(negedge CLK);
        checks++;
        if (n_valid != 0 || n_ferr != 0) begin
            errors++;
            $display("FAIL glitch_pulses: got valid=%0d ferr=%0d want 0 0", n_valid, n_ferr);
        end
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_lo: got %b want 0", bus.BUSY);
        end
        send_frame(8'h3C, 1'b1, BT4);
        repeat (20) @(negedge CLK);
        checks++;
        if (n_valid != 1 || bus.DATA !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_next: got valid=%0d data=%h want 1 3c", n_valid, bus.DATA);
        end
    endtask

    task automatic test_ferr();
        clear_mon();
        send_frame(8'h3C, 1'b0, BT4);
        send_bit(1'b0, BT4);
        checks++;
        if (n_ferr != 1 || n_valid != 0 || n_perr != 0) begin
            errors++;
            $display("FAIL ferr_pulses: got ferr=%0d valid=%0d perr=%0d want 1 0 0",
                     n_ferr, n_valid, n_perr);
        end
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL ferr_brk_busy: got %b want 1", bus.BUSY);
        end
        bus.RX = 1'b1;
        repeat (4) @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ferr_release: got %b want 0", bus.BUSY);
        end
        checks++;
        if (bus.DATA !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_data: got %h want 3c", bus.DATA);
        end
        repeat (20) @(negedge CLK);
    endtask

    task automatic test_overrun();
        clear_mon();
        bus.FULL = 1'b1;
        send_frame(8'h55, 1'b1, BT4);
        repeat (20) @(negedge CLK);
        bus.FULL = 1'b0;
        checks++;
        if (n_ovr != 1 || n_valid != 0) begin
            errors++;
            $display("FAIL overrun_pulses: got ovr=%0d valid=%0d want 1 0", n_ovr, n_valid);
        end
        checks++;
        if (bus.DATA !== 8'h3C) begin
            errors++;
            $display("FAIL overrun_data: got %h want 3c", bus.DATA);
        end
    endtask

    task automatic test_back_to_back();
        logic bits[$];
        logic [7:0] fr;
        int j_prev;
        int j_next;
        bus.BAUD = 4'd0;
        repeat (5) @(negedge CLK);
        clear_mon();
        for (int f = 0; f < 2; f++) begin
            fr = (f == 0) ? 8'h00 : 8'hFF;
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(fr[i]);
`ifdef UART_RX_PARITY_EN
            bits.push_back(^fr);
`endif
            bits.push_back(1'b1);
        end
        j_prev = 0;
        @(negedge CLK);
        for (int k = 0; k < bits.size(); k++) begin
            j_next = (k == bits.size() - 1) ? 0 : int'($urandom_range(62)) - 31;
            send_bit(bits[k], BT0 + j_next - j_prev);
            j_prev = j_next;
        end
        repeat (100) @(negedge CLK);
        checks++;
        if (n_valid != 2 || n_ferr != 0) begin
            errors++;
            $display("FAIL b2b_count: got valid=%0d ferr=%0d want 2 0", n_valid, n_ferr);
        end
        checks++;
        if (got.size() < 1 || got[0] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first: got %h want 00", (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (got.size() < 2 || got[1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second: got %h want ff", (got.size() > 1) ? got[1] : 8'hxx);
        end
        bus.BAUD = 4'd4;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_abort();
        clear_mon();
        send_partial(8'h81, BT4);
        RST = 1'b0;
        #1;
        checks++;
        if (bus.DATA !== 8'h00 || bus.BUSY !== 1'b0 ||
            {bus.VALID, bus.FERR, bus.OVERRUN, bus.PERR} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_rst: got data=%h busy=%b want 00 0", bus.DATA, bus.BUSY);
        end
        bus.RX = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        repeat (3 * BT4) @(negedge CLK);
        checks++;
        if (n_valid + n_ferr + n_ovr + n_perr != 0) begin
            errors++;
            $display("FAIL abort_rst_quiet: got %0d pulses want 0",
                     n_valid + n_ferr + n_ovr + n_perr);
        end
        clear_mon();
        send_frame(8'h81, 1'b1, BT4);
        repeat (20) @(negedge CLK);
        checks++;
        if (n_valid != 1 || bus.DATA !== 8'h81) begin
            errors++;
            $display("FAIL abort_resend: got valid=%0d data=%h want 1 81", n_valid, bus.DATA);
        end
        clear_mon();
        send_partial(8'h81, BT4);
        bus.EN = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL abort_en_busy: got %b want 0", bus.BUSY);
        end
        bus.RX = 1'b1;
        repeat (5) @(negedge CLK);
        bus.EN = 1'b1;
        repeat (3 * BT4) @(negedge CLK);
        checks++;
        if (n_valid + n_ferr + n_ovr + n_perr != 0 || bus.DATA !== 8'h81) begin
            errors++;
            $display("FAIL abort_en_quiet: got pulses=%0d data=%h want 0 81",
                     n_valid + n_ferr + n_ovr + n_perr, bus.DATA);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        b = 8'h81;
        clear_mon();
        @(negedge CLK);
        send_bit(1'b0, BT4);
        for (int i = 0; i < 8; i++) send_bit(b[i], BT4);
        send_bit(~^b, BT4);
        send_bit(1'b1, BT4);
        repeat (20) @(negedge CLK);
        checks++;
        if (n_perr != 1 || n_valid != 0 || n_ovr != 0) begin
            errors++;
            $display("FAIL parity_pulses: got perr=%0d valid=%0d want 1 0", n_perr, n_valid);
        end
        checks++;
        if (bus.DATA !== 8'h81) begin
            errors++;
            $display("FAIL parity_data: got %h want 81", bus.DATA);
        end
    endtask
`endif

    task automatic test_exclusive();
        checks++;
        if (n_multi != 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_multi);
        end
        checks++;
        if (perr_total != EXP_PERR) begin
            errors++;
            $display("FAIL perr_total: got %0d want %0d", perr_total, EXP_PERR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_ferr();
        test_overrun();
        test_back_to_back();
        test_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-side serial front end for uart_ctrl: synchronises RX, generates 16x oversample ticks from the BAUD code, and deserialises 8N1 frames (LSB first).
- Each good byte is delivered as a one-cycle VALID pulse into the controller's receive FIFO.
- Flags framing errors and FIFO overruns.

Parameters:
- CLK_HZ, 100000000: system clock frequency in Hz, used for divisor calculation.
- OVS, 16: oversample ratio. Fixed at 16; other values are unsupported.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-low reset
- EN  input  1  block enable
- RXEN  input  1  receiver enable
- BAUD  input  4  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600, 8-15=115200
- RX  input  1  serial line, idle high, asynchronous to CLK
- FULL  input  1  downstream FIFO full
- DATA  output  8  last received byte
- VALID  output  1  one-cycle pulse: DATA holds a new byte
- FERR  output  1  one-cycle pulse: stop bit sampled 0
- OVERRUN  output  1  one-cycle pulse: good byte dropped because FULL=1
- PERR  output  1  one-cycle parity error pulse; constant 0 without the optional feature
- BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Reset (RST=0, asynchronous):
  - DATA=0; VALID, FERR, OVERRUN, PERR, BUSY all 0.
  - Both synchroniser flops=1; state=IDLE; counters=0.
- RX passes through a 2-flop synchroniser. All decisions below use the synchronised value rx_s.
- Divisor: DIV = (CLK_HZ + 8*rate) / (16*rate), integer, computed at elaboration per BAUD code. At 100 MHz: 9600→651, 115200→54, 921600→7.
- Tick counter counts 0..DIV-1 and asserts tick when it reaches DIV-1. BAUD is sampled only in IDLE; changes mid-frame take effect on the next frame.
- Sample counter samp (4 bits) advances on each tick. Bit value = majority of rx_s captured at samp 7, 8, 9.
- States:
  - IDLE:
    - When EN & RXEN & rx_s=0: go to START.
    - Tick counter and samp cleared in the same cycle.
  - START:
    - At samp 9 with majority=1: glitch, return to IDLE with no outputs.
    - Otherwise, at samp 15 tick: go to DATA, bit index=0.
  - DATA:
    - At samp 15 tick, shift the majority value into shift[7] (right shift, LSB first).
    - After the 8th bit, go to STOP (or PARITY with the optional feature).
  - STOP: evaluated at samp 9.
    - majority=1 and FULL=0: DATA<=shift, VALID=1 for one cycle, go to IDLE.
    - majority=1 and FULL=1: OVERRUN=1 for one cycle, DATA unchanged, go to IDLE.
    - majority=0: FERR=1 for one cycle, no VALID, go to BRK.
  - BRK: stay until rx_s=1, then go to IDLE.
- Returning to IDLE at mid-stop-bit gives back-to-back frames the half-bit resync margin.
- Latency: VALID rises 9*16*DIV + 10*DIV (±2) cycles after the RX falling edge. At BAUD=4, 100 MHz this is 8316±2 cycles.
- EN=0 or RXEN=0 in any state: synchronous return to IDLE on the next cycle.
  - Partial frame discarded; no pulses; DATA retained.
- RST asserted mid-frame: immediate reset values.
- At most one of VALID, FERR, OVERRUN, PERR is high in any cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state between DATA and STOP samples the parity bit at samp 9 and advances at samp 15.
  - In STOP, if the 9-bit XOR is nonzero: PERR pulses once in place of VALID/OVERRUN, DATA unchanged, go to IDLE. A stop=0 still gives FERR alone.
- Undefined: no PARITY state; PERR tied 0; frame is 8N1.

Test Plan:
1. BAUD=4, FULL=0, send 0xA5 8N1 → single VALID pulse with DATA=0xA5, 8316±2 cycles after the RX fall; BUSY low afterwards.
2. RX low for 162 cycles (3 ticks at BAUD=4), then high → no VALID/FERR; BUSY returns to 0. A subsequent 0x3C frame is received correctly.
3. Send 0x3C with stop bit 0, hold RX low 2 bit-times, then high → one FERR pulse, no VALID. BUSY stays high until rx_s=1, then 0.
4. FULL=1 throughout 0x55 frame → one OVERRUN pulse, no VALID, DATA keeps previous value.
5. BAUD=0, back-to-back 0x00 then 0xFF with no idle gap, RX edges jittered ±3% → two VALID pulses, DATA=0x00 then 0xFF.
6. RST low (or EN low) at bit 4 of frame 0x81 → outputs at reset/IDLE values, no pulse. A resent 0x81 yields VALID with DATA=0x81. With UART_RX_PARITY_EN, sending 0x81 with wrong parity → PERR pulse and no VALID.
